ring_osc_meter: RTL
===================

Name: ring_osc_meter

Overview:
- Parametrised successor to the fixed ring-oscillator bank.
- Instantiates N_RINGS ring oscillators of increasing length. Only the selected ring is enabled.
- Divides the selected ring's output down and measures its frequency on-chip against clk over a programmable gate window.
- Presents the result as a saturating edge count, so silicon characterisation no longer depends on getting a >100 MHz signal off a pad.

Parameters:
- N_RINGS, 4: number of rings. Ring i has 2*(DEPTH_BASE<<i)+1 inverter stages.
- DEPTH_BASE, 62: inverter-pair count of ring 0 (125 stages).
- SEL_W, 2: ring select width, equal to clog2(N_RINGS).
- DIV_BITS, 4: ripple prescaler stages in the ring domain. Divide ratio is 2^DIV_BITS.
- GATE_BITS, 16: width of the gate-length input.
- CNT_WIDTH, 24: result width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle measurement request. Sampled only in IDLE.
- ring_sel  in  SEL_W  ring to measure. Latched on accepted start.
- gate_len  in  GATE_BITS  gate window in clk cycles. Latched on accepted start.
- busy  out  1  high from the cycle after accepted start until return to IDLE.
- done  out  1  one-cycle pulse when count is valid.
- count  out  CNT_WIDTH  divided-ring rising edges seen in the last gate window.
- overflow  out  1  count saturated in the last measurement.
- osc_div  out  1  prescaled output of the selected ring, for pad observation.

Behaviour:
- Reset values: busy=0, done=0, count=0, overflow=0. All ring enables are 0, so rings stop and osc_div settles to a static level. FSM goes to IDLE.
- Rings: each ring_osc has an en input that gates its first stage (NAND). At most one en is high, and only while busy.
- Prescaler (ring domain):
  - DIV_BITS toggle flops clocked by the selected ring output; no reset.
  - X at startup is acceptable. Only edges are counted, and WARMUP discards transients.
- Synchroniser: osc_div passes through a 2-FF synchroniser in clk plus one history flop.
  - rise = sync & ~hist.
  - Constraint: osc_div frequency < clk/2. Integration sizes DIV_BITS to meet it.
- FSM states: IDLE, WARMUP, GATE, DONE.
  - IDLE: on edge E0 with start=1, latch ring_sel and gate_len, clear the gate counter and edge accumulator, and go to WARMUP. busy=1 from E0.
  - WARMUP: 4 clk cycles (E1..E4). Selected ring is enabled. rise is ignored, which flushes the synchroniser and the ring start-up. Go to GATE at E4.
  - GATE: runs gate_len cycles; the accumulator increments on each rise sampled at E5..E4+gate_len. At E4+gate_len, load count and overflow from the accumulator and go to DONE.
  - gate_len=0: GATE is skipped and DONE follows WARMUP with count=0.
  - DONE: done=1 for exactly one cycle, then IDLE with busy=0. Ring enable drops on entry to DONE.
- Latency: done is high in the cycle after edge E4+gate_len. Accepted start to done = gate_len+5 cycles.
- Saturation: the accumulator sticks at 2^CNT_WIDTH-1 and sets overflow. It does not wrap.
- start while busy is ignored. No queuing.
- ring_sel/gate_len changes mid-measurement have no effect, since both were latched.
- ring_sel >= N_RINGS: no ring enabled, so the measurement completes with count=0.
- count and overflow hold between measurements and update only on entry to DONE.
- rst mid-measurement: the next cycle is IDLE with busy=0. done does not pulse and count clears to 0.

Decomposition:
- Package ring_osc_pkg holds:
  - state enum (IDLE, WARMUP, GATE, DONE);
  - WARMUP_CYCLES=4;
  - helper function for ring stage count.
- Sub-module ring_osc with an enable pin (DEPTH param, en input, osc_out output). It is the only ring-domain logic besides the prescaler, and is keep/dont_touch-constrained.
- The bench substitutes a behavioural ring_osc with a fixed period.

Test Plan:
- Model ring period 160 ns, DIV_BITS=4 (osc_div period 2560 ns), clk 20 ns. start with ring_sel=0, gate_len=1280 -> done at start+1285 cycles, count=10 (±1), overflow=0, busy high throughout.
- Same setup with gate_len=0 -> done 5 cycles after start, count=0. Only ring 0 en toggles, during WARMUP only.
- Same model, CNT_WIDTH overridden to 3, gate_len=12800 (~100 edges) -> count=7, overflow=1.
- start pulsed again mid-GATE with ring_sel=1 -> ignored. Result matches ring 0, and no second done.
- rst asserted in GATE cycle 500 -> next cycle busy=0, count=0, all en=0, no done pulse. A subsequent start completes normally.
- Four sequential measurements with model periods 160/320/640/1280 ns on ring_sel 0..3 and gate_len=5120 -> counts 40/20/10/5 (±1).

Source files
------------

// File: rtl/ring_osc_pkg.sv
// ring_osc_pkg: shared FSM encoding and ring sizing for the ring oscillator meter
package ring_osc_pkg;
  typedef enum logic [1:0] {IDLE, WARMUP, GATE, DONE} state_t;
  localparam int WARMUP_CYCLES = 4;
  function automatic int ring_stages(input int depth);
    return 2 * depth + 1;
  endfunction
endpackage

// File: rtl/ring_osc.sv
// ring_osc: NAND-gated inverter ring, held intact at integration by keep/dont_touch constraints
module ring_osc
  import ring_osc_pkg::*;
#(
  parameter int DEPTH = 62
) (
  input  logic en,
  output logic osc_out
);
  localparam int STAGES = ring_stages(DEPTH);
  logic [STAGES-1:0] w_stage;
  assign w_stage[0] = ~(en & w_stage[STAGES-1]);
  for (genvar k = 1; k < STAGES; k++) begin : g_inv
    assign w_stage[k] = ~w_stage[k-1];
  end
  assign osc_out = w_stage[STAGES-1];
endmodule

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: selects one ring, prescales it and counts its edges against clk over a gate window
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int N_RINGS         = 4,
  parameter int DEPTH_BASE      = 62,
  parameter int SEL_W           = 2,
  parameter int DIV_BITS        = 4,
  parameter int GATE_BITS       = 16,
  parameter int CNT_WIDTH       = 24,
  parameter int MODEL_HALF_CLKS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_W-1:0]     ring_sel,
  input  logic [GATE_BITS-1:0] gate_len,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 osc_div
);
  state_t r_state, w_next;
  logic [SEL_W-1:0] r_sel;
  logic [GATE_BITS-1:0] r_gate, r_cyc;
  logic [CNT_WIDTH-1:0] r_acc, w_acc;
  logic r_ovf, w_ovf, r_en, w_ring_sel, r_hist, w_rise;
  logic [N_RINGS-1:0] w_en, w_ring;
  logic [DIV_BITS-1:0] w_div, w_dclk;
  logic [1:0] r_sync;
  for (genvar i = 0; i < N_RINGS; i++) begin : g_ring
    assign w_en[i] = r_en && r_sel == SEL_W'(i);
    if (MODEL_HALF_CLKS == 0) begin : g_si
      ring_osc #(.DEPTH(DEPTH_BASE << i)) u_ring (.en(w_en[i]), .osc_out(w_ring[i]));
    end else begin : g_model
      logic [31:0] r_mcnt;
      logic r_mosc;
      // simulation stand-in: square wave of (MODEL_HALF_CLKS<<i) clk half-period, static low when disabled
      always_ff @(posedge clk) begin
        r_mcnt <= (rst || !w_en[i] || r_mcnt == 32'(MODEL_HALF_CLKS << i) - 32'd1) ? '0 : r_mcnt + 32'd1;
        r_mosc <= (rst || !w_en[i]) ? 1'b0 : r_mosc ^ (r_mcnt == 32'(MODEL_HALF_CLKS << i) - 32'd1);
      end
      assign w_ring[i] = r_mosc;
    end
  end
  assign w_ring_sel = |(w_ring & w_en);
  assign w_dclk = {~w_div[DIV_BITS-2:0], w_ring_sel};
  for (genvar k = 0; k < DIV_BITS; k++) begin : g_div
    logic r_q;
    // ripple prescaler stage; no reset, start-up state is flushed by WARMUP
    always_ff @(posedge w_dclk[k]) begin
      r_q <= ~r_q;
    end
    assign w_div[k] = r_q;
  end
  assign osc_div = w_div[DIV_BITS-1];
  // bring the prescaled ring into clk and keep one sample of history for edge detection
  always_ff @(posedge clk) begin
    r_sync <= rst ? 2'b00 : {r_sync[0], osc_div};
    r_hist <= rst ? 1'b0 : r_sync[1];
  end
  assign w_rise = r_sync[1] & ~r_hist;
  assign w_acc = (w_rise && r_acc != '1) ? r_acc + CNT_WIDTH'(1) : r_acc;
  assign w_ovf = r_ovf | (w_rise & (r_acc == '1));
  // measurement state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // next-state and status outputs
  always_comb begin
    w_next = r_state;
    busy = r_state != IDLE;
    done = r_state == DONE;
    if (r_state == IDLE && start) w_next = WARMUP;
    if (r_state == WARMUP && r_cyc == GATE_BITS'(WARMUP_CYCLES - 1)) w_next = (r_gate == '0) ? DONE : GATE;
    if (r_state == GATE && r_cyc == r_gate - GATE_BITS'(1)) w_next = DONE;
    if (r_state == DONE) w_next = IDLE;
  end
  // latched request, in-state cycle counter, edge accumulator and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
      r_gate <= '0;
      r_cyc <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_en <= 1'b0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      r_en <= w_next == WARMUP || w_next == GATE;
      r_cyc <= (w_next != r_state || r_state == IDLE) ? '0 : r_cyc + GATE_BITS'(1);
      if (r_state == IDLE && start) begin
        r_sel <= ring_sel;
        r_gate <= gate_len;
        r_acc <= '0;
        r_ovf <= 1'b0;
      end
      if (r_state == GATE) begin
        r_acc <= w_acc;
        r_ovf <= w_ovf;
      end
      if (w_next == DONE) begin
        count <= (r_state == GATE) ? w_acc : r_acc;
        overflow <= (r_state == GATE) ? w_ovf : r_ovf;
      end
    end
  end
endmodule
